// File: rtl/image_proc_pkg.sv
// Shared constants, types and helpers for the image-processing line-buffer controller.
package image_proc_pkg;

  localparam int unsigned LINE_WIDTH = 512;
  localparam int unsigned PIXEL_W    = 8;
  localparam int unsigned NUM_BUFS   = 4;
  localparam int unsigned KERNEL     = 3;

  function automatic int unsigned stored_width(int unsigned lw, int unsigned nb);
    return $clog2(nb * lw + 1);
  endfunction

  localparam int unsigned STORED_W = stored_width(LINE_WIDTH, NUM_BUFS);

  // Index of the buffer 'ofs' positions after 'sel' in a ring of n buffers.
  function automatic int unsigned ring_idx(int unsigned sel, int unsigned ofs, int unsigned n);
    return (sel + ofs) % n;
  endfunction

  typedef enum logic {IDLE, RD} lbc_state_e;

endpackage

// File: rtl/lbc_wrap_counter.sv
// Modulo-N counter with enable; wrap pulses on the enabled cycle that returns the count to 0.
module lbc_wrap_counter #(
  parameter int unsigned N = 4,
  parameter int unsigned W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         axi_clk,
  input  logic         axi_rst,
  input  logic         en,
  output logic [W-1:0] count,
  output logic         wrap
);

  assign wrap = en && (count == W'(N - 1));

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/line_buffer_ctrl.sv
// Steers pixels into a four-line-buffer ring and reads three filled lines as 3x3 windows.
module line_buffer_ctrl #(
  parameter int unsigned LINE_WIDTH = image_proc_pkg::LINE_WIDTH,
  parameter int unsigned PIXEL_W    = image_proc_pkg::PIXEL_W,
  parameter int unsigned NUM_BUFS   = image_proc_pkg::NUM_BUFS,
  parameter int unsigned KERNEL     = image_proc_pkg::KERNEL
) (
  input  logic                                axi_clk,
  input  logic                                axi_rst,
  input  logic [PIXEL_W-1:0]                  pixel_in,
  input  logic                                pixel_vin,
  output logic                                slave_ready,
  output logic [NUM_BUFS-1:0]                 lb_wr_en,
  output logic [PIXEL_W-1:0]                  lb_wr_data,
  output logic [NUM_BUFS-1:0]                 lb_rd_en,
  input  logic [NUM_BUFS*KERNEL*PIXEL_W-1:0]  lb_rd_data,
  input  logic                                master_ready,
  output logic [KERNEL*KERNEL*PIXEL_W-1:0]    window_out,
  output logic                                window_valid,
  output logic                                intr,
  output logic                                ovf
);
  import image_proc_pkg::*;

  localparam int unsigned PTR_W  = $clog2(LINE_WIDTH);
  localparam int unsigned SEL_W  = $clog2(NUM_BUFS);
  localparam int unsigned CNT_W  = stored_width(LINE_WIDTH, NUM_BUFS);
  localparam int unsigned TAP_W  = KERNEL * PIXEL_W;
  localparam int unsigned CAP    = NUM_BUFS * LINE_WIDTH;
  localparam int unsigned THRESH = KERNEL * LINE_WIDTH;

  lbc_state_e                      state_q;
  logic [CNT_W-1:0]                stored_q;
  logic [PTR_W-1:0]                wr_ptr, rd_ptr;
  logic [SEL_W-1:0]                wr_sel, rd_sel;
  logic                            wr_wrap, rd_wrap, wr_sel_wrap, rd_sel_wrap;
  logic                            accept, step;
  logic [KERNEL*KERNEL*PIXEL_W-1:0] window_d, window_q;
  logic                            window_valid_q, intr_q, ovf_q;
  logic                            unused_sel_wrap;

  assign slave_ready = stored_q < CNT_W'(CAP);
  assign accept      = pixel_vin & slave_ready;
  assign step        = (state_q == RD) & master_ready;
  assign lb_wr_data  = pixel_in;

  assign unused_sel_wrap = wr_sel_wrap ^ rd_sel_wrap;

  lbc_wrap_counter #(.N(LINE_WIDTH), .W(PTR_W)) u_wr_ptr (
    .axi_clk (axi_clk),
    .axi_rst (axi_rst),
    .en      (accept),
    .count   (wr_ptr),
    .wrap    (wr_wrap)
  );

  lbc_wrap_counter #(.N(NUM_BUFS), .W(SEL_W)) u_wr_sel (
    .axi_clk (axi_clk),
    .axi_rst (axi_rst),
    .en      (wr_wrap),
    .count   (wr_sel),
    .wrap    (wr_sel_wrap)
  );

  lbc_wrap_counter #(.N(LINE_WIDTH), .W(PTR_W)) u_rd_ptr (
    .axi_clk (axi_clk),
    .axi_rst (axi_rst),
    .en      (step),
    .count   (rd_ptr),
    .wrap    (rd_wrap)
  );

  lbc_wrap_counter #(.N(NUM_BUFS), .W(SEL_W)) u_rd_sel (
    .axi_clk (axi_clk),
    .axi_rst (axi_rst),
    .en      (rd_wrap),
    .count   (rd_sel),
    .wrap    (rd_sel_wrap)
  );

  always_comb begin
    lb_wr_en         = '0;
    lb_wr_en[wr_sel] = accept;
  end

  // Oldest line (rd_sel) lands in the low row of the window.
  always_comb begin
    lb_rd_en = '0;
    window_d = '0;
    for (int unsigned k = 0; k < KERNEL; k++) begin
      lb_rd_en[SEL_W'(ring_idx(32'(rd_sel), k, NUM_BUFS))] = step;
      window_d[k*TAP_W +: TAP_W] =
          lb_rd_data[ring_idx(32'(rd_sel), k, NUM_BUFS)*TAP_W +: TAP_W];
    end
  end

  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      state_q        <= IDLE;
      stored_q       <= '0;
      window_q       <= '0;
      window_valid_q <= 1'b0;
      intr_q         <= 1'b0;
      ovf_q          <= 1'b0;
    end else begin
      case ({accept, step})
        2'b10:   stored_q <= stored_q + 1'b1;
        2'b01:   stored_q <= stored_q - 1'b1;
        default: ;
      endcase
      ovf_q          <= ovf_q | (pixel_vin & ~slave_ready);
      window_valid_q <= step;
      intr_q         <= rd_wrap;
      if (step) window_q <= window_d;
      case (state_q)
        IDLE:    if (stored_q >= CNT_W'(THRESH)) state_q <= RD;
        RD:      if (rd_wrap) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign window_out   = window_q;
  assign window_valid = window_valid_q;
  assign intr         = intr_q;
  assign ovf          = ovf_q;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Randomised bench for line_buffer_ctrl against a line-level reference model.
module tb_line_buffer_ctrl;

  localparam int LW = 8;

  logic        axi_clk = 1'b0;
  logic        axi_rst = 1'b0;
  logic [7:0]  pixel_in = '0;
  logic        pixel_vin = 1'b0;
  logic        master_ready = 1'b0;
  logic        slave_ready;
  logic [3:0]  lb_wr_en, lb_rd_en;
  logic [7:0]  lb_wr_data;
  logic [95:0] lb_rd_data;
  logic [71:0] window_out;
  logic        window_valid, intr, ovf;

  always #5 axi_clk = ~axi_clk;

  line_buffer_ctrl #(.LINE_WIDTH(LW)) dut (
    .axi_clk      (axi_clk),
    .axi_rst      (axi_rst),
    .pixel_in     (pixel_in),
    .pixel_vin    (pixel_vin),
    .slave_ready  (slave_ready),
    .lb_wr_en     (lb_wr_en),
    .lb_wr_data   (lb_wr_data),
    .lb_rd_en     (lb_rd_en),
    .lb_rd_data   (lb_rd_data),
    .master_ready (master_ready),
    .window_out   (window_out),
    .window_valid (window_valid),
    .intr         (intr),
    .ovf          (ovf)
  );

  // Line buffer environment: four memories with their own write/read pointers.
  logic [7:0] mem [4][LW];
  int         wp [4];
  int         rp [4];

  always_comb begin
    lb_rd_data = '0;
    for (int b = 0; b < 4; b++)
      for (int t = 0; t < 3; t++)
        lb_rd_data[b*24 + t*8 +: 8] = mem[b][(rp[b] + t) % LW];
  end

  // Reference model: pixel history as a flat list of lines, plus pass bookkeeping.
  int          hist [2048];
  int          m_stored, m_rd_pos, m_pass, m_wr_count;
  bit          m_reading, m_wv, m_intr, m_ovf;
  logic [71:0] m_win;

  int n_checks = 0;
  int n_fail   = 0;
  int n_intr, n_win;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] rd_mask(input int p);
    logic [3:0] m = '0;
    for (int k = 0; k < 3; k++) m[(p + k) % 4] = 1'b1;
    return m;
  endfunction

  // Window at position r of pass p: rows are lines p, p+1, p+2, each three pixels wide.
  function automatic logic [71:0] exp_window(input int p, input int r);
    logic [71:0] w = '0;
    for (int j = 0; j < 3; j++)
      for (int t = 0; t < 3; t++)
        w[(j*3 + t)*8 +: 8] = 8'(hist[(p + j)*LW + (r + t) % LW]);
    return w;
  endfunction

  task automatic model_reset();
    m_stored = 0; m_rd_pos = 0; m_pass = 0; m_wr_count = 0;
    m_reading = 0; m_wv = 0; m_intr = 0; m_ovf = 0; m_win = '0;
    n_intr = 0; n_win = 0;
    for (int b = 0; b < 4; b++) begin
      wp[b] = 0;
      rp[b] = 0;
      for (int i = 0; i < LW; i++) mem[b][i] = 8'h00;
    end
  endtask

  task automatic reset_dut();
    pixel_vin = 1'b0;
    #2 axi_rst = 1'b1;
    #1;
    check("rst_slave_ready", slave_ready, 1'b1);
    check("rst_outputs", {lb_wr_en, lb_rd_en, window_out, window_valid, intr, ovf}, '0);
    @(posedge axi_clk);
    #1 axi_rst = 1'b0;
    model_reset();
  endtask

  task automatic cycle(input logic vin, input logic [7:0] px, input logic mr);
    logic       exp_ready, acc, stp;
    logic [3:0] exp_wr, cap_wr, cap_rd;
    logic [7:0] cap_data;
    pixel_vin = vin; pixel_in = px; master_ready = mr;
    @(negedge axi_clk);
    check("window_valid", window_valid, m_wv);
    if (m_wv) check("window_out", window_out, m_win);
    check("intr", intr, m_intr);
    check("ovf", ovf, m_ovf);
    if (window_valid) n_win++;
    if (intr) n_intr++;
    exp_ready = m_stored < 4 * LW;
    acc       = vin && exp_ready;
    stp       = m_reading && mr;
    exp_wr    = '0;
    if (acc) exp_wr[(m_wr_count / LW) % 4] = 1'b1;
    check("slave_ready", slave_ready, exp_ready);
    check("lb_wr_en", lb_wr_en, exp_wr);
    if (acc) check("lb_wr_data", lb_wr_data, px);
    check("lb_rd_en", lb_rd_en, stp ? rd_mask(m_pass % 4) : 4'b0000);
    check("no_overlap", lb_wr_en & lb_rd_en, 4'b0000);
    cap_wr = lb_wr_en; cap_rd = lb_rd_en; cap_data = lb_wr_data;
    @(posedge axi_clk);
    #1;
    for (int b = 0; b < 4; b++) begin
      if (cap_wr[b]) begin
        mem[b][wp[b]] = cap_data;
        wp[b] = (wp[b] + 1) % LW;
      end
      if (cap_rd[b]) rp[b] = (rp[b] + 1) % LW;
    end
    if (vin && !exp_ready) m_ovf = 1;
    if (acc) begin
      hist[m_wr_count] = int'(px);
      m_wr_count++;
    end
    m_wv   = stp;
    m_intr = stp && (m_rd_pos == LW - 1);
    if (stp) m_win = exp_window(m_pass, m_rd_pos);
    if (m_reading) begin
      if (stp) begin
        m_rd_pos++;
        if (m_rd_pos == LW) begin
          m_rd_pos = 0; m_pass++; m_reading = 0;
        end
      end
    end else if (m_stored >= 3 * LW) begin
      m_reading = 1;
    end
    m_stored = m_stored + int'(acc) - int'(stp);
  endtask

  task automatic wait_intr(input int target, input int budget, input string tag);
    int k = 0;
    while (n_intr < target && k < budget) begin
      cycle(1'b0, 8'h00, 1'b1);
      k++;
    end
    check(tag, n_intr >= target, 1'b1);
  endtask

  task automatic first_three_lines(input string tag);
    for (int i = 0; i < 3 * LW; i++) cycle(1'b1, 8'(i), 1'b1);
    wait_intr(1, 40, {tag, "_intr_wait"});
    repeat (2) cycle(1'b0, 8'h00, 1'b1);
    check({tag, "_intr_count"}, n_intr, 1);
    check({tag, "_windows"}, n_win, 8);
  endtask

  initial begin
    model_reset();
    reset_dut();

    // Three lines then one full pass.
    first_three_lines("s1");

    // Full 8x8 image plus two padding lines, each new line sent after a buffer frees.
    reset_dut();
    for (int i = 0; i < 3 * LW; i++) cycle(1'b1, 8'($urandom), 1'b1);
    for (int ln = 3; ln < 10; ln++) begin
      wait_intr(ln - 2, 60, "s2_intr_wait");
      for (int i = 0; i < LW; i++) cycle(1'b1, 8'($urandom), 1'b1);
    end
    wait_intr(8, 60, "s2_last_wait");
    repeat (2) cycle(1'b0, 8'h00, 1'b1);
    check("s2_intr_count", n_intr, 8);
    check("s2_windows", n_win, 64);
    check("s2_ovf", ovf, 1'b0);

    // Fill all four buffers with reads stalled, then overflow.
    reset_dut();
    for (int i = 0; i < 4 * LW; i++) cycle(1'b1, 8'($urandom), 1'b0);
    check("s3_full", slave_ready, 1'b0);
    cycle(1'b1, 8'hAA, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("s3_ovf", ovf, 1'b1);

    // Stall every other cycle during a pass.
    n_win = 0; n_intr = 0;
    for (int k = 0; k < 40 && n_intr == 0; k++) cycle(1'b0, 8'h00, (k % 2) == 0);
    check("s4_windows", n_win, 8);
    check("s4_intr_count", n_intr, 1);
    check("s4_ovf_sticky", ovf, 1'b1);

    // Write exactly on read steps across five passes; both selects wrap 3 -> 0.
    reset_dut();
    for (int i = 0; i < 3 * LW; i++) cycle(1'b1, 8'($urandom), 1'b0);
    for (int k = 0; k < 150 && m_pass < 5; k++) cycle(m_reading, 8'($urandom), 1'b1);
    repeat (2) cycle(1'b0, 8'h00, 1'b0);
    check("s5_intr_count", n_intr, 5);
    check("s5_stored", dut.stored_q, 3 * LW);

    // Asynchronous reset mid-pass, then the first scenario again.
    reset_dut();
    for (int i = 0; i < 3 * LW; i++) cycle(1'b1, 8'($urandom), 1'b1);
    for (int k = 0; k < 20 && !(m_reading && m_rd_pos == 4); k++) cycle(1'b0, 8'h00, 1'b1);
    check("s6_mid_pass", m_reading && m_rd_pos == 4, 1'b1);
    master_ready = 1'b1;
    reset_dut();
    first_three_lines("s6");

    // Random traffic; the writer never runs more than one line ahead of the active pass.
    reset_dut();
    for (int k = 0; k < 600; k++) begin
      logic ok;
      ok = (m_wr_count / LW) <= m_pass + 3;
      cycle(ok && ($urandom_range(0, 3) != 0), 8'($urandom), $urandom_range(0, 2) != 0);
    end
    check("s7_progress", n_intr > 5, 1'b1);
    check("s7_ovf", ovf, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
